// File: rtl/load_store_unit.sv
// Load/store unit: runs the data-memory req/gnt/rvalid handshake, formats store lanes
// and extends load data. Define LSU_MISALIGN_TRAP_EN to abort misaligned accesses.
module load_store_unit #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              data_req_i,
  input  logic              data_wr_i,
  input  logic [1:0]        data_byte_i,
  input  logic              zero_extnd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wr_data_i,
  output logic              stall_o,
  output logic              rd_valid_o,
  output logic [31:0]       rd_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0]  SZ_BYTE  = 2'b00;
  localparam logic [1:0]  SZ_HALF  = 2'b01;
  localparam logic [1:0]  SZ_WORD  = 2'b10;
  localparam logic        TMO_EN   = (RSP_TIMEOUT != 32'd0);
  localparam logic [31:0] TMO_LAST = 32'(RSP_TIMEOUT) - 32'd1;

  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    case (sz)
      2'b00:   norm_size = SZ_BYTE;
      2'b01:   norm_size = SZ_HALF;
      default: norm_size = SZ_WORD;
    endcase
  endfunction

  // Offset within the word after rounding down to the access size.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: align_lo = lo;
      SZ_HALF: align_lo = {lo[1], 1'b0};
      default: align_lo = 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << lo;
      SZ_HALF: lane_be = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: lane_wdata = {4{wd[7:0]}};
      SZ_HALF: lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0] sz, input logic ext,
                                               input logic [1:0] lo, input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> {lo, 3'b000};
    case (sz)
      SZ_BYTE: load_extract = {{24{~ext & sh[7]}}, sh[7:0]};
      SZ_HALF: load_extract = {{16{~ext & sh[15]}}, sh[15:0]};
      default: load_extract = sh;
    endcase
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction
`endif

  state_t             state_r;
  state_t             state_s;
  logic               wr_r;
  logic [1:0]         size_r;
  logic               ext_r;
  logic [1:0]         lo_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [3:0]         be_r;
  logic [31:0]        wdata_r;
  logic [31:0]        rd_data_r;
  logic               err_r;
  logic [31:0]        cnt_r;
  logic [1:0]         size_in_s;
  logic [1:0]         lo_in_s;
  logic               trap_s;
  logic               tmo_s;
  logic               err_s;
  logic               cap_s;

  assign size_in_s = norm_size(data_byte_i);
  assign lo_in_s   = align_lo(size_in_s, addr_i[1:0]);
  assign tmo_s     = TMO_EN && (cnt_r >= TMO_LAST);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_s = misaligned(size_in_s, addr_i[1:0]);
`else
  assign trap_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; a completing handshake wins over a timeout in the same cycle.
  always_comb begin
    state_s = state_r;
    err_s   = 1'b0;
    cap_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (data_req_i) begin
          state_s = trap_s ? DONE : REQ;
          err_s   = trap_s;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_gnt_i && (wr_r || mem_rvalid_i)) begin
          state_s = DONE;
          cap_s   = ~wr_r;
        end else if (tmo_s) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else if (mem_gnt_i) begin
          state_s = RSP;
        end else begin
          state_s = REQ;
        end
      end
      RSP: begin
        if (mem_rvalid_i) begin
          state_s = DONE;
          cap_s   = 1'b1;
        end else if (tmo_s) begin
          state_s = DONE;
          err_s   = 1'b1;
        end else begin
          state_s = RSP;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latch: lanes and enables are computed once so they stay stable until grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      ext_r   <= 1'b0;
      lo_r    <= 2'b00;
      addr_r  <= '0;
      be_r    <= 4'b0000;
      wdata_r <= 32'h0000_0000;
    end else if ((state_r == IDLE) && data_req_i) begin
      wr_r    <= data_wr_i;
      size_r  <= size_in_s;
      ext_r   <= zero_extnd_i;
      lo_r    <= lo_in_s;
      addr_r  <= {addr_i[ADDR_W-1:2], 2'b00};
      be_r    <= lane_be(size_in_s, lo_in_s);
      wdata_r <= lane_wdata(size_in_s, wr_data_i);
    end
  end

  // Timeout counter, abort flag and captured load data.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_r     <= 32'd0;
      err_r     <= 1'b0;
      rd_data_r <= 32'h0000_0000;
    end else begin
      if ((state_r == REQ) || (state_r == RSP)) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= 32'd0;
      end
      err_r <= err_s;
      if (cap_s) begin
        rd_data_r <= load_extract(size_r, ext_r, lo_r, mem_rdata_i);
      end
    end
  end

  // Output decode; the IDLE stall is combinational so the request itself holds the pipe.
  always_comb begin
    stall_o     = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = 4'b0000;
    mem_wdata_o = 32'h0000_0000;
    done_o      = 1'b0;
    err_o       = 1'b0;
    rd_valid_o  = 1'b0;
    rd_data_o   = 32'h0000_0000;
    case (state_r)
      IDLE: stall_o = data_req_i & rst_n_i;
      REQ: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = wr_r;
        mem_addr_o  = addr_r;
        mem_be_o    = be_r;
        mem_wdata_o = wdata_r;
      end
      RSP: stall_o = 1'b1;
      DONE: begin
        done_o = 1'b1;
        err_o  = err_r;
        if (~wr_r && ~err_r) begin
          rd_valid_o = 1'b1;
          rd_data_o  = rd_data_r;
        end else begin
          rd_valid_o = 1'b0;
          rd_data_o  = 32'h0000_0000;
        end
      end
      default: stall_o = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit (RSP_TIMEOUT=4); honours LSU_MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        data_req_i;
  logic        data_wr_i;
  logic [1:0]  data_byte_i;
  logic        zero_extnd_i;
  logic [31:0] addr_i;
  logic [31:0] wr_data_i;
  logic        stall_o;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        done_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  logic [33:0] exp_q[$];
  int          n_cmp   = 0;
  int          n_err   = 0;
  int          req_cnt = 0;

  always #5 clk_i = ~clk_i;

  load_store_unit #(.ADDR_W(32), .RSP_TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .data_req_i(data_req_i), .data_wr_i(data_wr_i),
    .data_byte_i(data_byte_i), .zero_extnd_i(zero_extnd_i), .addr_i(addr_i),
    .wr_data_i(wr_data_i), .stall_o(stall_o), .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
    .done_o(done_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard: every done_o pulse pops one expected {err, rd_valid, rd_data}.
  always @(negedge clk_i) begin
    logic [33:0] e;
    if (mem_req_o) req_cnt++;
    if (done_o) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_done", {31'd0, done_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("done_err", {31'd0, err_o}, {31'd0, e[33]});
        check_eq("done_rd_valid", {31'd0, rd_valid_o}, {31'd0, e[32]});
        check_eq("done_rd_data", rd_data_o, e[31:0]);
      end
    end else if (rd_valid_o || err_o) begin
      check_eq("pulse_without_done", {30'd0, rd_valid_o, err_o}, 32'd0);
    end
  end

  // One transaction; inputs change 1ns after posedge, outputs sampled on negedge.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic ext,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_rd);
    exp_q.push_back({1'b0, ~wr, e_rd});
    req_cnt = 0;
    @(posedge clk_i); #1;
    data_req_i = 1'b1; data_wr_i = wr; data_byte_i = sz; zero_extnd_i = ext;
    addr_i = addr; wr_data_i = wd;
    @(negedge clk_i);
    check_eq("idle_stall", {31'd0, stall_o}, 32'd1);
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    for (int k = 0; k <= gnt_dly; k++) begin
      mem_gnt_i    = (k == gnt_dly);
      mem_rvalid_i = (k == gnt_dly) && (rv_dly == 0) && !wr;
      mem_rdata_i  = mem_rvalid_i ? rdata : 32'h0;
      @(negedge clk_i);
      if (k == 0) begin
        check_eq("req_stall", {31'd0, stall_o}, 32'd1);
        check_eq("mem_req", {31'd0, mem_req_o}, 32'd1);
        check_eq("mem_we", {31'd0, mem_we_o}, {31'd0, wr});
        check_eq("mem_addr", mem_addr_o, e_addr);
        check_eq("mem_be", {28'd0, mem_be_o}, {28'd0, e_be});
        if (wr) check_eq("mem_wdata", mem_wdata_o, e_wd);
      end
      @(posedge clk_i); #1;
    end
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    if (!wr && rv_dly > 0) begin
      for (int k = 1; k <= rv_dly; k++) begin
        mem_rvalid_i = (k == rv_dly);
        mem_rdata_i  = mem_rvalid_i ? rdata : 32'h0;
        @(negedge clk_i);
        if (k == 1) check_eq("rsp_req_low", {31'd0, mem_req_o}, 32'd0);
        @(posedge clk_i); #1;
      end
      mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    end
    @(negedge clk_i);
    check_eq("done_pulse", {31'd0, done_o}, 32'd1);
    check_eq("done_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy;
    logic seen;
    rst_n_i = 1'b0; data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'b00;
    zero_extnd_i = 1'b0; addr_i = 32'h0; wr_data_i = 32'h0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_ctl", {26'd0, stall_o, mem_req_o, mem_we_o, done_o, err_o, rd_valid_o}, 32'd0);
    check_eq("rst_addr_be", mem_addr_o | {28'd0, mem_be_o}, 32'd0);
    check_eq("rst_data", rd_data_o | mem_wdata_o, 32'd0);
    data_req_i = 1'b0;
    #2 rst_n_i = 1'b1;
    @(posedge clk_i); #1;

    // SW, grant in the second REQ cycle
    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 1, 0, 32'h0,
            32'h100, 4'b1111, 32'hDEADBEEF, 32'h0);
    check_eq("sw_req_cycles", req_cnt, 32'd2);
    run_txn(1'b1, 2'b00, 1'b0, 32'h103, 32'h000000A5, 0, 0, 32'h0,
            32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234ABCD, 0, 0, 32'h0,
            32'h100, 4'b1100, 32'hABCDABCD, 32'h0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h102, 32'h0, 0, 1, 32'h0080FF00,
            32'h100, 4'b0100, 32'h0, 32'hFFFFFF80);
    run_txn(1'b0, 2'b00, 1'b1, 32'h102, 32'h0, 0, 2, 32'h0080FF00,
            32'h100, 4'b0100, 32'h0, 32'h00000080);
    run_txn(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 1, 1, 32'h00007F00,
            32'h100, 4'b0010, 32'h0, 32'h0000007F);
    // LH/LHU with grant and rvalid together: done two cycles after the request
    run_txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 0, 32'h80011234,
            32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
    run_txn(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 1, 0, 32'h80011234,
            32'h100, 4'b1100, 32'h0, 32'h00008001);
    run_txn(1'b0, 2'b11, 1'b1, 32'h204, 32'h0, 0, 1, 32'h87654321,
            32'h204, 4'b1111, 32'h0, 32'h87654321);

`ifdef LSU_MISALIGN_TRAP_EN
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    req_cnt = 0;
    data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'b10; addr_i = 32'h101;
    @(posedge clk_i); #1;
    data_req_i = 1'b0;
    @(negedge clk_i);
    check_eq("trap_done", {30'd0, done_o, err_o}, 32'd3);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_eq("trap_no_req", req_cnt, 32'd0);
    @(posedge clk_i); #1;
`else
    run_txn(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 1, 32'hCAFEF00D,
            32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
`endif

    // Timeout: granted load never answered; REQ+RSP must last exactly 4 cycles
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'b10; addr_i = 32'h200;
    @(posedge clk_i); #1;
    data_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(negedge clk_i);
    check_eq("tmo_req", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    busy = 1; seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (done_o) seen = 1'b1;
      else if (stall_o) busy++;
      @(posedge clk_i); #1;
    end
    check_eq("tmo_done_seen", {31'd0, seen}, 32'd1);
    check_eq("tmo_busy_cycles", busy, 32'd4);
    // stray rvalid after abort must be ignored
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11111111;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk_i); #1;

    // Reset in RSP: outputs drop at once, transaction dropped without done_o
    data_req_i = 1'b1; data_wr_i = 1'b0; data_byte_i = 2'b10; addr_i = 32'h300;
    @(posedge clk_i); #1;
    data_req_i = 1'b0; mem_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    mem_gnt_i = 1'b0;
    @(negedge clk_i);
    check_eq("rsp_stall", {31'd0, stall_o}, 32'd1);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("midrst_ctl", {26'd0, stall_o, mem_req_o, mem_we_o, done_o, err_o, rd_valid_o}, 32'd0);
    check_eq("midrst_data", rd_data_o | mem_addr_o, 32'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22222222;
    @(posedge clk_i); #1;
    mem_rvalid_i = 1'b0;
    repeat (4) @(posedge clk_i); #1;

    check_eq("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-side counterpart to the core's decode/control stage.
- Consumes the decoded data request, size, write and zero-extend controls plus the ALU address, and runs the request/grant/response handshake to the data memory port.
- Formats store data and byte enables, and extracts and extends load data for register-file writeback.
- Stalls the pipeline for the whole transaction.

Parameters:
- ADDR_W, 32, address width (byte address).
- RSP_TIMEOUT, 255, max cycles spent in REQ+RSP before abort; 0 disables timeout.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  async reset, active-low
- data_req_i  in  1  memory access requested (from control)
- data_wr_i  in  1  1=store, 0=load
- data_byte_i  in  2  size: 00 BYTE, 01 HALF_WORD, 10 WORD; 11 treated as WORD
- zero_extnd_i  in  1  load zero-extend (LBU/LHU)
- addr_i  in  ADDR_W  byte address (ALU result)
- wr_data_i  in  32  store data (rs2)
- stall_o  out  1  hold pipeline
- rd_valid_o  out  1  load data valid, 1-cycle pulse
- rd_data_o  out  32  extended load data
- done_o  out  1  transaction complete, 1-cycle pulse (loads and stores)
- err_o  out  1  timeout or misalign abort, 1-cycle pulse with done_o
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  ADDR_W  word-aligned address (low 2 bits 0)
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-aligned write data
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data

Behaviour:
- Reset (async, rst_n_i=0): state IDLE; all outputs 0; timeout counter 0; latched request cleared. Reset mid-transaction abandons it with no done_o.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE:
  - On data_req_i=1, latch wr, size, ext, addr and wdata; go to REQ next cycle.
  - stall_o = data_req_i (combinational).
- REQ:
  - mem_req_o=1; mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o held stable until grant.
  - On mem_gnt_i: store -> DONE; load -> RSP, or -> DONE directly if mem_rvalid_i is also 1 in the same cycle (data captured).
- RSP:
  - mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i and go to DONE.
  - mem_rvalid_i outside REQ/RSP is ignored.
- DONE (one cycle):
  - done_o=1, stall_o=0.
  - Load: rd_valid_o=1 with extended data.
  - Next state IDLE; a data_req_i seen in DONE is not accepted until IDLE.
- stall_o=1 in REQ and RSP.
- Load latency: grant and rvalid in the same cycle -> done_o 2 cycles after data_req_i.
- Byte enables:
  - BYTE: 1<<addr[1:0].
  - HALF: addr[1] ? 1100 : 0011.
  - WORD: 1111.
- Store data: BYTE replicated {4{wdata[7:0]}}, HALF {2{wdata[15:0]}}, WORD unchanged.
- Load extract:
  - Shift mem_rdata right by addr[1:0]*8.
  - BYTE: bits[7:0], sign- or zero-extended per ext.
  - HALF: bits[15:0], likewise.
  - WORD: unchanged (ext ignored).
- Timeout:
  - Counter cleared on entering REQ; increments each cycle in REQ/RSP.
  - When it reaches RSP_TIMEOUT (nonzero): go to DONE with err_o=1, rd_valid_o=0, rd_data_o=0.
  - Any later stray rvalid is ignored.
- Misalign: HALF with addr[0]=1, or WORD with addr[1:0]!=0.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined: a misaligned request goes IDLE->DONE next cycle with err_o=1, done_o=1, rd_valid_o=0, and no mem_req_o.
- Not defined: misaligned requests proceed; the address is aligned down to the access size (HALF clears bit0, WORD clears bits[1:0]) before computing be and lanes; err_o is never set by misalignment.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt after 2 cycles -> mem_addr=0x100, be=1111, we=1, mem_req held 2 cycles, then done_o pulse, stall_o released.
- SB addr=0x103, wdata=0x000000A5 -> be=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x102, rdata=0x0080FF00, zero_extnd=0 -> rd_data=0xFFFFFF80, rd_valid_o pulse. LBU same -> 0x00000080.
- LH addr=0x102, rdata=0x8001xxxx -> rd_data=0xFFFF8001. LHU -> 0x00008001. gnt+rvalid in the same cycle -> done_o 2 cycles after req.
- RSP_TIMEOUT=4, load granted, no rvalid -> done_o+err_o at cycle 4, rd_data=0. Assert rst_n_i=0 mid-RSP on a second run -> all outputs 0 immediately, no done_o.
- LW addr=0x101 -> with LSU_MISALIGN_TRAP_EN: err_o+done_o next cycle, mem_req_o never 1. Without: mem_addr=0x100, be=1111, err_o=0.
